// File: rtl/noc_link_tx_if.sv
// Buffer-read and link-side signals of the NoC link transmitter.
// The master modport is the transmitter. The slave modport is its environment:
// the upstream input buffer together with the downstream link receiver.
interface noc_link_tx_if #(
  parameter int DATA_W = 16
);
  logic              buf_empty_i;
  logic              buf_valid_i;
  logic [DATA_W-1:0] buf_data_i;
  logic              buf_read_o;
  logic              link_credit_i;
  logic              link_valid_o;
  logic [DATA_W-1:0] link_data_o;

  modport master (
    input  buf_empty_i, buf_valid_i, buf_data_i, link_credit_i,
    output buf_read_o, link_valid_o, link_data_o
  );

  modport slave (
    output buf_empty_i, buf_valid_i, buf_data_i, link_credit_i,
    input  buf_read_o, link_valid_o, link_data_o
  );
endinterface

// File: rtl/noc_link_tx.sv
// NoC link transmitter: drains flits from the router input buffer onto the link.
// It uses credit-based flow control, reserving a credit when a read is issued,
// tracks head/tail packet framing and raises sticky error flags.
module noc_link_tx #(
  parameter int DATA_W  = 16,
  parameter int CREDITS = 8,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  noc_link_tx_if.master    bus,
  output logic [CNT_W-1:0] credit_cnt_o,
  output logic             pkt_active_o,
  output logic             credit_err_o,
  output logic             fmt_err_o
);

  typedef enum logic {
    S_IDLE,
    S_BODY
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CREDITS);

  logic [CNT_W-1:0]  credit_cnt_q, credit_cnt_d;
  logic              credit_err_q, credit_err_d;
  logic              rd_issue;
  logic              link_valid_q;
  logic [DATA_W-1:0] link_data_q;
  state_t            state_q;
  logic              pkt_active_q;
  logic              fmt_err_q;
  logic              flit_head;
  logic              flit_tail;

  // A read is only issued with a credit in hand.
  // The credit is reserved at issue, so the flit always has a downstream slot.
  assign rd_issue       = !reset && !bus.buf_empty_i && (credit_cnt_q != '0);
  assign bus.buf_read_o = rd_issue;

  assign flit_head = bus.buf_data_i[DATA_W-1];
  assign flit_tail = bus.buf_data_i[DATA_W-2];

  // Credit counter: -1 per read issued, +1 per credit returned.
  // A return on a full count saturates and flags an error.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    credit_cnt_d = credit_cnt_q;
    credit_err_d = credit_err_q;
    case ({rd_issue, bus.link_credit_i})
      2'b10: credit_cnt_d = credit_cnt_q - CNT_W'(1);
      2'b01: begin
        if (credit_cnt_q == CNT_MAX) credit_err_d = 1'b1;
        else                         credit_cnt_d = credit_cnt_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  // Credit state registers. Reset restores the full credit count.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments; reset is synchronous and checked first.
    if (reset) begin
      credit_cnt_q <= CNT_MAX;
      credit_err_q <= 1'b0;
    end else begin
      credit_cnt_q <= credit_cnt_d;
      credit_err_q <= credit_err_d;
    end
  end

  // Registered datapath: forward every valid flit, hold the last data when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      link_valid_q <= 1'b0;
      link_data_q  <= '0;
    end else begin
      link_valid_q <= bus.buf_valid_i;
      if (bus.buf_valid_i) link_data_q <= bus.buf_data_i;
    end
  end

  // Framing FSM, advanced once per forwarded flit. Errors never stall forwarding.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pkt_active_q <= 1'b0;
      fmt_err_q    <= 1'b0;
    end else if (bus.buf_valid_i) begin
      case (state_q)
        S_IDLE: begin
          if (!flit_head) begin
            fmt_err_q <= 1'b1;
          end else if (!flit_tail) begin
            state_q      <= S_BODY;
            pkt_active_q <= 1'b1;
          end
        end
        S_BODY: begin
          // An unexpected head restarts a packet.
          // In BODY the tail bit alone decides whether the packet ends.
          if (flit_head) fmt_err_q <= 1'b1;
          if (flit_tail) begin
            state_q      <= S_IDLE;
            pkt_active_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          pkt_active_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.link_valid_o = link_valid_q;
  assign bus.link_data_o  = link_data_q;
  assign credit_cnt_o     = credit_cnt_q;
  assign credit_err_o     = credit_err_q;
  assign pkt_active_o     = pkt_active_q;
  assign fmt_err_o        = fmt_err_q;

endmodule

// File: tb/tb_noc_link_tx.sv
// Self-checking bench for noc_link_tx.
// The bench acts as the upstream buffer (a flit queue) and as the downstream credit source.
// A packet-level reference model predicts the read gate, credits, framing and errors.
// Forwarded flits go into a scoreboard queue that a separate link monitor drains.
module tb_noc_link_tx;
  localparam int DATA_W  = 16;
  localparam int CREDITS = 8;
  localparam int CNT_W   = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [CNT_W-1:0] credit_cnt;
  logic             pkt_active, credit_err, fmt_err;

  always #5 clk = ~clk;

  noc_link_tx_if #(.DATA_W(DATA_W)) bus_if ();

  noc_link_tx #(.DATA_W(DATA_W), .CREDITS(CREDITS), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus_if),
    .credit_cnt_o (credit_cnt),
    .pkt_active_o (pkt_active),
    .credit_err_o (credit_err),
    .fmt_err_o    (fmt_err)
  );

  // Reference model state
  logic [DATA_W-1:0] src_q[$];   // contents of the emulated upstream buffer
  logic [DATA_W-1:0] exp_q[$];   // flits expected on the link
  int                m_cnt = CREDITS;
  bit                m_cerr, m_ferr, m_in_pkt;
  bit                pend_vld;
  logic [DATA_W-1:0] pend_data = '0;
  logic [DATA_W-1:0] last_data = '0;
  int                checks = 0;
  int                errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet framing rules: a head opens a packet and a tail closes it.
  // A head inside a packet, or a non-head outside one, is a framing error.
  task automatic frame(input logic [DATA_W-1:0] f);
    if (f[DATA_W-1]) begin
      if (m_in_pkt) m_ferr = 1'b1;
      m_in_pkt = !f[DATA_W-2];
    end else if (!m_in_pkt) begin
      m_ferr = 1'b1;
    end else if (f[DATA_W-2]) begin
      m_in_pkt = 1'b0;
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_credit_cnt"}, 32'(credit_cnt), 32'(m_cnt));
    check({tag, "_pkt_active"}, 32'(pkt_active), 32'(m_in_pkt));
    check({tag, "_credit_err"}, 32'(credit_err), 32'(m_cerr));
    check({tag, "_fmt_err"},    32'(fmt_err),    32'(m_ferr));
  endtask

  // One clock of stimulus plus model update. credit = downstream frees one slot this cycle.
  task automatic step(input bit credit);
    bit exp_rd;
    @(negedge clk);
    bus_if.buf_empty_i   = (src_q.size() == 0);
    bus_if.buf_valid_i   = pend_vld;
    bus_if.buf_data_i    = pend_vld ? pend_data : DATA_W'($urandom);
    bus_if.link_credit_i = credit;
    #1;
    exp_rd = (src_q.size() != 0) && (m_cnt != 0);
    check("buf_read", 32'(bus_if.buf_read_o), 32'(exp_rd));
    if (pend_vld) begin
      exp_q.push_back(pend_data);
      frame(pend_data);
    end
    if (exp_rd && !credit) m_cnt--;
    else if (!exp_rd && credit) begin
      if (m_cnt == CREDITS) m_cerr = 1'b1;
      else                  m_cnt++;
    end
    pend_vld = exp_rd;
    if (exp_rd) pend_data = src_q.pop_front();
    @(posedge clk);
    #1;
    check_status("step");
  endtask

  // Two-cycle reset. A flit still in flight is presented during reset and must be dropped.
  task automatic do_reset();
    @(negedge clk);
    reset                = 1'b1;
    bus_if.buf_valid_i   = pend_vld;
    bus_if.buf_data_i    = pend_data;
    bus_if.buf_empty_i   = 1'b0;
    bus_if.link_credit_i = 1'b1;
    exp_q.delete();
    src_q.delete();
    last_data = '0;
    pend_vld  = 1'b0;
    m_cnt     = CREDITS;
    m_cerr    = 1'b0;
    m_ferr    = 1'b0;
    m_in_pkt  = 1'b0;
    #1;
    check("read_in_reset", 32'(bus_if.buf_read_o), 32'd0);
    @(negedge clk);
    bus_if.buf_valid_i   = 1'b0;
    bus_if.link_credit_i = 1'b0;
    @(posedge clk);
    #1;
    check_status("reset");
    check("reset_link_valid", 32'(bus_if.link_valid_o), 32'd0);
    @(negedge clk);
    reset              = 1'b0;
    bus_if.buf_empty_i = 1'b1;
  endtask

  // Enqueue a well-formed packet; corrupt flips the head bit of one flit.
  task automatic push_pkt(input int len, input bit corrupt);
    int bad;
    bad = $urandom_range(0, len - 1);
    for (int i = 0; i < len; i++) begin
      logic [DATA_W-1:0] f;
      f = DATA_W'($urandom) & {2'b00, {(DATA_W-2){1'b1}}};
      f[DATA_W-1] = (i == 0);
      f[DATA_W-2] = (i == len - 1);
      if (corrupt && i == bad) f[DATA_W-1] = ~f[DATA_W-1];
      src_q.push_back(f);
    end
  endtask

  // Link monitor: each valid flit must match the oldest expected flit.
  // Every expected flit must show up two cycles after its read. Data holds while idle.
  always @(posedge clk) begin
    #1;
    if (bus_if.link_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL link_unexpected: got flit %0h expected none at %0t", bus_if.link_data_o, $time);
      end else begin
        check("link_data", 32'(bus_if.link_data_o), 32'(exp_q.pop_front()));
      end
      last_data = bus_if.link_data_o;
    end else begin
      if (exp_q.size() != 0) begin
        checks++;
        errors++;
        $display("FAIL link_missing: got no flit expected %0h at %0t", exp_q.pop_front(), $time);
      end
      check("link_hold", 32'(bus_if.link_data_o), 32'(last_data));
    end
  end

  initial begin
    reset                = 1'b1;
    bus_if.buf_empty_i   = 1'b1;
    bus_if.buf_valid_i   = 1'b0;
    bus_if.buf_data_i    = '0;
    bus_if.link_credit_i = 1'b0;

    // T1: reset values
    do_reset();

    // T2: single-flit packet
    src_q.push_back(16'hC000);
    repeat (4) step(1'b0);
    check("t2_cnt", 32'(credit_cnt), 32'd7);

    // T3: credit exhaustion, then a single credit releases exactly one more flit
    do_reset();
    push_pkt(10, 1'b0);
    repeat (12) step(1'b0);
    check("t3_cnt_zero", 32'(credit_cnt), 32'd0);
    check("t3_src_left", 32'(src_q.size()), 32'd2);
    step(1'b1);
    repeat (4) step(1'b0);
    check("t3_src_after", 32'(src_q.size()), 32'd1);

    // T4: read and credit return in the same cycle
    do_reset();
    push_pkt(10, 1'b0);
    repeat (5) step(1'b0);
    step(1'b1);
    check("t4_cnt_hold", 32'(credit_cnt), 32'd3);

    // T5: credit overflow and a headless flit
    do_reset();
    step(1'b1);
    check("t5_credit_err", 32'(credit_err), 32'd1);
    src_q.push_back(16'h0001);
    repeat (4) step(1'b0);
    check("t5_fmt_err", 32'(fmt_err), 32'd1);

    // T6: reset in the middle of a packet
    do_reset();
    src_q.push_back(16'h8000);
    src_q.push_back(16'h0123);
    src_q.push_back(16'h0456);
    repeat (3) step(1'b0);
    check("t6_active", 32'(pkt_active), 32'd1);
    do_reset();
    check("t6_cnt", 32'(credit_cnt), 32'd8);

    // Random traffic: mostly legal packets, occasional corruption, random credit returns
    for (int round = 0; round < 4; round++) begin
      do_reset();
      for (int cyc = 0; cyc < 250; cyc++) begin
        if (src_q.size() < 12 && $urandom_range(0, 3) == 0)
          push_pkt($urandom_range(1, 5), ($urandom_range(0, 19) == 0));
        step((m_cnt < CREDITS) && ($urandom_range(0, 2) != 0));
      end
      // Drain: return credits until everything queued has been sent
      for (int cyc = 0; cyc < 200 && (src_q.size() != 0 || pend_vld); cyc++)
        step(m_cnt < CREDITS);
      step(1'b0);
      check("drain_src", 32'(src_q.size()), 32'd0);
      check("drain_sb", 32'(exp_q.size()), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
